// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding AXI-lite read master feeding decode.
// Latency: AR issued cycle N, R accepted N+1 (1-cycle slave), inst_valid at N+2.
// Backpressure: inst/inst_pc held while inst_ready is low; no new AR until the instruction is consumed.
// Optional feature: define IFU_FAULT_EN to flag non-OKAY responses and halt until redirect.
module ifu_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  // INIT is the reset-time "request pending" state: it keeps arvalid low
  // until the first clock edge after reset releases.
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;            // address of the current/next fetch, drives araddr
  logic              redir_pend_q, redir_pend_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d; // target parked while an AR is in flight
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] redir_al;
  logic [ADDR_W-1:0] redir_tgt;
  logic              resp_done;
  logic              resp_err;
  logic              unused_lsb;

  assign redir_al   = {redirect_pc[ADDR_W-1:2], 2'b00};
  // A redirect arriving now supersedes one already parked (last wins).
  assign redir_tgt  = redirect_valid ? redir_al : redir_pc_q;
  assign unused_lsb = ^redirect_pc[1:0];

`ifdef IFU_FAULT_EN
  assign resp_err = (rresp != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign resp_err     = 1'b0;
`endif

  // The read response completes either together with AR in REQ or later in WAIT.
  assign resp_done = ((state_q == S_REQ) && arready && rvalid) ||
                     ((state_q == S_WAIT) && rvalid);

  // Next-state and datapath selection for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = fault_q;
    case (state_q)
      S_INIT: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redir_al;
      end
      S_REQ, S_WAIT: begin
        if (resp_done) begin
          if (redirect_valid || redir_pend_q) begin
            // Stale response: drop it and refetch from the redirect target.
            pc_d         = redir_tgt;
            redir_pend_d = 1'b0;
            state_d      = S_REQ;
          end else begin
            inst_d    = resp_err ? NOP : rdata;
            inst_pc_d = pc_q;
            fault_d   = resp_err;
            state_d   = S_OUT;
          end
        end else begin
          // araddr must stay stable while AR is pending, so park the target.
          if (redirect_valid) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redir_al;
          end
          if ((state_q == S_REQ) && arready) state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redir_al;
          fault_d = 1'b0;
          state_d = S_REQ;
        end else if (inst_ready) begin
          if (fault_q) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(4);
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_d    = redir_al;
          fault_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= RESET_PC;
      inst_q       <= NOP;
      inst_pc_q    <= RESET_PC;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
    end
  end

  assign araddr     = pc_q;
  assign arvalid    = (state_q == S_REQ);
  assign rready     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign inst_valid = (state_q == S_OUT);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
`ifdef IFU_FAULT_EN
  assign inst_fault = fault_q;
`else
  assign inst_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a one-cycle AXI-lite read slave model.
// Slave returns addr ^ 32'h8010_0093, so 8000_0000 reads 32'h0010_0093.
// Build with +define+IFU_FAULT_EN to exercise the fault path.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;

  logic        ar_rdy   = 1'b1;
  logic        r_hold   = 1'b0;
  logic        err_resp = 1'b0;
  logic        s_pend;
  logic [31:0] s_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  // Slave: accept AR, present R from the next cycle until accepted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pend <= 1'b0;
      s_addr <= 32'h0;
    end else begin
      if (rvalid && rready) s_pend <= 1'b0;
      if (arvalid && arready) begin
        s_pend <= 1'b1;
        s_addr <= araddr;
      end
    end
  end
  assign arready = ar_rdy;
  assign rvalid  = s_pend && !r_hold;
  assign rdata   = s_addr ^ 32'h8010_0093;
  assign rresp   = err_resp ? 2'b10 : 2'b00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b exp=0", rready); end
    total++; if (araddr !== 32'h8000_0000) begin bad++; $display("FAIL rst_araddr got=%h exp=80000000", araddr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
    total++; if (inst_pc !== 32'h8000_0000) begin bad++; $display("FAIL rst_inst_pc got=%h exp=80000000", inst_pc); end
    total++; if (inst_fault !== 1'b0) begin bad++; $display("FAIL rst_inst_fault got=%b exp=0", inst_fault); end
    rst = 1'b0;
    #1;
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL post_rst_arvalid got=%b exp=0", arvalid); end
  endtask

  task automatic test_first_fetch();
    tick(); // cycle N: AR
    total++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0000}) begin bad++; $display("FAIL first_ar got=%b/%h exp=1/80000000", arvalid, araddr); end
    tick(); // cycle N+1: R
    total++; if ({arvalid, rready, inst_valid} !== 3'b010) begin bad++; $display("FAIL first_wait got=%b exp=010", {arvalid, rready, inst_valid}); end
    tick(); // cycle N+2: inst_valid
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0093, 32'h8000_0000}) begin bad++; $display("FAIL first_inst got=%b/%h/%h exp=1/00100093/80000000", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({inst_valid, arvalid, rready, inst, inst_pc} !== {3'b100, 32'h0010_0093, 32'h8000_0000}) begin
        bad++; $display("FAIL stall_%0d got=%b%b%b/%h/%h exp=100/00100093/80000000", i, inst_valid, arvalid, rready, inst, inst_pc);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if ({arvalid, inst_valid, araddr} !== {2'b10, 32'h8000_0004}) begin bad++; $display("FAIL stall_next_ar got=%b%b/%h exp=10/80000004", arvalid, inst_valid, araddr); end
    tick(); tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0097, 32'h8000_0004}) begin bad++; $display("FAIL stall_next_inst got=%b/%h/%h exp=1/00100097/80000004", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_wait();
    r_hold     = 1'b1;
    inst_ready = 1'b1;
    tick(); // REQ 8000_0008
    inst_ready = 1'b0;
    tick(); // WAIT, response held off
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    total++; if ({arvalid, rready, inst_valid} !== 3'b010) begin bad++; $display("FAIL rdw_wait got=%b exp=010", {arvalid, rready, inst_valid}); end
    r_hold = 1'b0;
    tick(); // stale response discarded
    total++; if ({arvalid, inst_valid, araddr} !== {2'b10, 32'h8000_0100}) begin bad++; $display("FAIL rdw_ar got=%b%b/%h exp=10/80000100", arvalid, inst_valid, araddr); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_no_stale got=%b exp=0", inst_valid); end
    tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0193, 32'h8000_0100}) begin bad++; $display("FAIL rdw_inst got=%b/%h/%h exp=1/00100193/80000100", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_out();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    total++; if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0010}) begin bad++; $display("FAIL rdo_drop got=%b%b/%h exp=01/80000010", inst_valid, arvalid, araddr); end
    tick(); tick();
    total++; if ({inst_valid, inst_pc} !== {1'b1, 32'h8000_0010}) begin bad++; $display("FAIL rdo_inst got=%b/%h exp=1/80000010", inst_valid, inst_pc); end
    // redirect and consume in the same cycle: redirect target wins over pc+4
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    total++; if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0040}) begin bad++; $display("FAIL rdo_ready_ar got=%b%b/%h exp=01/80000040", inst_valid, arvalid, araddr); end
    tick(); tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_00D3, 32'h8000_0040}) begin bad++; $display("FAIL rdo_ready_inst got=%b/%h/%h exp=1/001000d3/80000040", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h7FEF_FF6F, 32'hFFFF_FFFC}) begin bad++; $display("FAIL wrap_top got=%b/%h/%h exp=1/7feff f6f/fffffffc", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0000}) begin bad++; $display("FAIL wrap_ar got=%b/%h exp=1/00000000", arvalid, araddr); end
    tick(); tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h8010_0093, 32'h0000_0000}) begin bad++; $display("FAIL wrap_inst got=%b/%h/%h exp=1/80100093/00000000", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_req();
    ar_rdy     = 1'b0;
    inst_ready = 1'b1;
    tick(); // REQ 0000_0004, stalled by slave
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    total++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0004}) begin bad++; $display("FAIL rdr_stable got=%b/%h exp=1/00000004", arvalid, araddr); end
    redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    ar_rdy         = 1'b1;
    tick(); // AR accepted
    tick(); // response discarded
    total++; if ({arvalid, inst_valid, araddr} !== {2'b10, 32'h8000_0300}) begin bad++; $display("FAIL rdr_last_wins got=%b%b/%h exp=10/80000300", arvalid, inst_valid, araddr); end
    tick(); tick();
    total++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0393, 32'h8000_0300}) begin bad++; $display("FAIL rdr_inst got=%b/%h/%h exp=1/00100393/80000300", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_fault();
    err_resp   = 1'b1;
    inst_ready = 1'b1;
    tick(); // REQ 8000_0304
    inst_ready = 1'b0;
    tick(); tick();
    err_resp = 1'b0;
`ifdef IFU_FAULT_EN
    total++; if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b11, 32'h0000_0013, 32'h8000_0304}) begin bad++; $display("FAIL fault_flag got=%b%b/%h/%h exp=11/00000013/80000304", inst_valid, inst_fault, inst, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({arvalid, inst_valid, inst_fault} !== 3'b001) begin bad++; $display("FAIL fault_halt_%0d got=%b exp=001", i, {arvalid, inst_valid, inst_fault}); end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    total++; if ({arvalid, inst_fault, araddr} !== {2'b10, 32'h8000_0400}) begin bad++; $display("FAIL fault_clear got=%b%b/%h exp=10/80000400", arvalid, inst_fault, araddr); end
`else
    total++; if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b10, 32'h0010_0397, 32'h8000_0304}) begin bad++; $display("FAIL resp_ignored got=%b%b/%h/%h exp=10/00100397/80000304", inst_valid, inst_fault, inst, inst_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0308}) begin bad++; $display("FAIL resp_no_halt got=%b/%h exp=1/80000308", arvalid, araddr); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_redirect_req();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
